// File: rtl/vram_ctrl.sv
// vram_ctrl: single-port VRAM arbiter between a display line fetcher (with word FIFO) and a CPU port
// Ports: clk, reset (async active-high); cpu_req/we/addr/din -> cpu_ack/dout;
// disp_start/row/pop -> disp_valid/word; VRAM p_read/p_addr/p_dout and s_write/s_addr/s_din/s_dout/s_busy.
// Optional macro VRAM_CTRL_UNDERRUN_EN adds a sticky 'underrun' output for pops on an empty FIFO during FETCH.
module vram_ctrl #(
  parameter int WORDS_PER_LINE = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
  input  logic        disp_start,
  input  logic [7:0]  disp_row,
  output logic        disp_valid,
  output logic [15:0] disp_word,
  input  logic        disp_pop,
  output logic        p_read,
  output logic [12:0] p_addr,
  input  logic [15:0] p_dout,
  output logic        s_write,
  output logic [12:0] s_addr,
  output logic [15:0] s_din,
  input  logic [15:0] s_dout,
  input  logic        s_busy
`ifdef VRAM_CTRL_UNDERRUN_EN
  ,
  output logic        underrun
`endif
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [12:0] LAST = 13'(WORDS_PER_LINE - 1);

  logic [0:0]  r_state;
  logic [12:0] r_base, r_idx;
  logic        r_prev_disp, r_busy, r_ack;
  logic [2:0]  r_dq, r_cq;
  logic [15:0] r_dout;
  logic [15:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;

  logic [AW+1:0] w_level;
  logic [12:0] w_row_base;
  logic w_disp_ok, w_cpu_go, w_issue_cpu, w_issue_disp, w_push, w_pop;

  // r_dq/r_cq are 3-deep shift registers: bit 2 marks the cycle in which the read data is on the bus.
  // Counting every in-flight display read against the FIFO keeps the FIFO from ever overflowing.
  assign w_level      = (AW+2)'(r_cnt) + (AW+2)'(r_dq[0]) + (AW+2)'(r_dq[1]) + (AW+2)'(r_dq[2]);
  assign w_row_base   = 13'(disp_row * WORDS_PER_LINE);
  assign w_disp_ok    = !reset && r_state == FETCH && !disp_start && w_level < (AW+2)'(FIFO_DEPTH);
  assign w_cpu_go     = !reset && cpu_req && !r_busy;
  // CPU takes the slot whenever the display cannot use it, or the display had the previous slot.
  assign w_issue_cpu  = w_cpu_go && (!w_disp_ok || r_prev_disp);
  assign w_issue_disp = w_disp_ok && !w_issue_cpu;
  assign w_push       = r_dq[2] && !disp_start;
  assign w_pop        = disp_pop && disp_valid && !disp_start;

  assign p_read     = w_issue_disp;
  assign p_addr     = w_issue_disp ? r_base + r_idx : 13'd0;
  assign s_write    = w_issue_cpu && cpu_we;
  assign s_addr     = w_issue_cpu ? cpu_addr : 13'd0;
  assign s_din      = s_write ? cpu_din : 16'd0;
  assign cpu_ack    = r_ack;
  assign cpu_dout   = r_dout;
  assign disp_valid = r_cnt != '0;
  assign disp_word  = disp_valid ? r_mem[r_rp] : 16'd0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_idx       <= '0;
      r_prev_disp <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_dq        <= '0;
      r_cq        <= '0;
      r_dout      <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
    end else begin
      r_prev_disp <= w_issue_disp;
      // Busy from issue through the ack cycle, so a still-held request is not re-issued.
      r_busy      <= w_issue_cpu | (r_busy & ~r_ack);
      r_ack       <= (w_issue_cpu & cpu_we) | r_cq[2];
      r_cq        <= {r_cq[1:0], w_issue_cpu & ~cpu_we};
      if (r_cq[2]) r_dout <= s_dout;
      // A new line discards in-flight display reads and empties the FIFO.
      r_dq        <= disp_start ? 3'b000 : {r_dq[1:0], w_issue_disp};
      r_wp        <= disp_start ? '0 : r_wp + AW'(w_push);
      r_rp        <= disp_start ? '0 : r_rp + AW'(w_pop);
      r_cnt       <= disp_start ? '0 : r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (disp_start) begin
        r_state <= FETCH;
        r_base  <= w_row_base;
        r_idx   <= '0;
      end else if (w_issue_disp) begin
        r_state <= (r_idx == LAST) ? IDLE : FETCH;
        r_idx   <= r_idx + 13'd1;
      end
    end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= p_dout;

`ifdef VRAM_CTRL_UNDERRUN_EN
  logic r_under;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_under <= 1'b0;
    else r_under <= disp_start ? 1'b0 : r_under | (disp_pop & ~disp_valid & (r_state == FETCH));
  assign underrun = r_under;
`endif

  a_busy: assert property (@(posedge clk) disable iff (reset) s_busy == p_read);
endmodule
